uart_rx_buffered: RTL and testbench
===================================

// Module: uart_rx_buffered
// PURPOSE
//   UART receiver (8N1, LSB first) with a receive FIFO. It sits on the device side of the serial line,
//   opposite the UART_TX transmitter. Samples RX_Serial at mid-bit and checks the stop bit.
//   Good bytes are buffered so a slow consumer can drain bursts; framing and overrun errors are flagged.
// PARAMETERS
//   CLKS_PER_BIT  868  clocks per bit (100 MHz / 115200 baud); must be >= 4
//   FIFO_DEPTH    16   receive FIFO entries; power of two, >= 2
//   ADDR_W        4    log2(FIFO_DEPTH); set consistently with FIFO_DEPTH
// PORTS
//   Clock         in   1         system clock, all logic on rising edge
//   Reset_n       in   1         asynchronous, active-low reset
//   RX_Serial     in   1         serial line, idle high, asynchronous to Clock
//   RX_Rd_En      in   1         pop head byte (ignored when RX_Empty)
//   RX_Bytes      out  8         FIFO head byte, first-word fall-through; valid when !RX_Empty
//   RX_Empty      out  1         FIFO empty
//   RX_Full       out  1         FIFO holds FIFO_DEPTH bytes
//   RX_Count      out  ADDR_W+1  bytes currently stored, 0..FIFO_DEPTH
//   RX_Frame_Err  out  1         1-cycle pulse: stop bit sampled low, byte dropped
//   RX_Overrun    out  1         1-cycle pulse: good byte arrived while full with no pop, byte dropped
// BEHAVIOUR
//   Reset: FSM=IDLE, counters 0, FIFO emptied. RX_Empty=1, RX_Full=0, RX_Count=0, RX_Bytes=0,
//     error pulses 0, both synchroniser flops=1.
//   Sync: RX_Serial passes through 2 flops (rx_s) before the FSM sees it. Adds 2 cycles of latency.
//   FSM (clk_cnt counts 0..CLKS_PER_BIT-1, bit_idx counts 0..7):
//     IDLE : rx_s==0 -> START, clk_cnt=0.
//     START: at clk_cnt==(CLKS_PER_BIT-1)/2, re-sample. rx_s==0 -> DATA, clk_cnt=0.
//            rx_s==1 is a glitch -> IDLE, nothing flagged.
//     DATA : at clk_cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx] (LSB first) and reset clk_cnt.
//            After bit 7 -> STOP.
//     STOP : at clk_cnt==CLKS_PER_BIT-1, sample. 1 -> push shreg, -> IDLE.
//            0 -> RX_Frame_Err for 1 cycle, no push, -> WAIT_HI.
//     WAIT_HI: stays until rx_s==1, then -> IDLE. This prevents a break condition re-triggering START.
//   Push/pop:
//     Push happens in the stop-sample cycle. RX_Empty falls and RX_Bytes updates on the next edge.
//     Pop with RX_Rd_En && !RX_Empty. RX_Bytes shows the next entry on the following edge.
//     Push+pop in the same cycle: both happen and RX_Count is unchanged.
//       When full, the push is accepted and there is no overrun.
//     Push when full with no pop: byte dropped, RX_Overrun pulses 1 cycle, FIFO contents untouched.
//     Pop when empty: no effect and no error.
//   Pointers: wr/rd ptr ADDR_W bits, wrap modulo FIFO_DEPTH. Count is tracked separately, ADDR_W+1 bits.
//   Latency: start-edge at pin to push is 2 sync cycles + about 9.5 bit times.
//   Back-to-back frames: a new start bit is accepted the first IDLE cycle after a good stop sample.
//   Reset mid-frame: partial byte discarded, FIFO cleared, FSM=IDLE immediately (asynchronous).
// STRUCTURE
//   uart_defs.vh: FSM state localparams (IDLE, START, DATA, STOP, WAIT_HI) as 3-bit codes.
//     The same file holds the shared UART bit-frame constants (DATA_BITS=8), shared with UART_TX.
//   Sub-module sync_fifo #(WIDTH=8, DEPTH, ADDR_W): show-ahead FIFO with full/empty/count.
//     It also reports a push-while-full error. Reusable for a future TX buffer.
//   Top holds the synchroniser, the FSM, shreg and the error pulse generation.
// TESTING (CLKS_PER_BIT=868, FIFO_DEPTH=16, 10 ns clock, stimulus from a UART_TX instance)
//   1. Send 8'h37, no pops -> RX_Empty falls, RX_Bytes=8'h37, RX_Count=1, no error pulses.
//   2. Send 8'h00, 8'hFF, 8'hA5 back-to-back, then pop 3 times -> reads 00, FF, A5 in order.
//      RX_Empty=1 afterwards.
//   3. Send a frame 8'h55 with the stop bit forced low for one bit time -> RX_Frame_Err pulses once.
//      RX_Count stays 0. A following 8'h12 frame is received correctly.
//   4. Pull the line low for 300 clocks only (glitch) -> FSM returns to IDLE. No push, no error.
//   5. Send 17 bytes 8'h01..8'h11 with no pops -> RX_Full=1, RX_Count=16, RX_Overrun pulses once.
//      Draining yields 8'h01..8'h10. Repeat with RX_Rd_En asserted in the 17th push cycle: no overrun.
//   6. Assert Reset_n=0 mid-DATA of a frame after 3 bytes are queued -> RX_Empty=1, RX_Count=0.
//      The next full frame 8'hC3 is received cleanly.

Source files
------------

// File: rtl/uart_rx_buffered_pkg.sv
// Shared UART frame constants and receiver FSM state encoding.
package uart_rx_buffered_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and push-while-full error flag.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              push_err_o
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign push_err_o = push_i && full_o && !do_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, receive FIFO and error pulses.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              RX_Serial,
  input  logic              RX_Rd_En,
  output logic [7:0]        RX_Bytes,
  output logic              RX_Empty,
  output logic              RX_Full,
  output logic [ADDR_W:0]   RX_Count,
  output logic              RX_Frame_Err,
  output logic              RX_Overrun
);

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  logic                  sync1_q;
  logic                  rx_s_q;
  rx_state_e             state_q;
  logic [CNT_W-1:0]      clk_cnt_q;
  logic [BIT_IDX_W-1:0]  bit_idx_q;
  logic [DATA_BITS-1:0]  shreg_q;
  logic                  frame_err_q;
  logic                  overrun_q;
  logic                  push;
  logic                  push_err;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= RX_Serial;
      rx_s_q    <= sync1_q;
      overrun_q <= push_err;
    end
  end

  // Good stop bit: the byte is written into the FIFO on this same edge.
  assign push = (state_q == ST_STOP) && (clk_cnt_q == LAST_CNT) && rx_s_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_s_q) state_q <= ST_START;
        end
        ST_START: begin
          if (clk_cnt_q == MID_CNT) begin
            clk_cnt_q <= '0;
            state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (clk_cnt_q == LAST_CNT) begin
            clk_cnt_q          <= '0;
            shreg_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (clk_cnt_q == LAST_CNT) begin
            clk_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HI;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        // A held-low line (break) must return high before a new start bit is looked for.
        ST_WAIT_HI: begin
          if (rx_s_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH  (DATA_BITS),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i      (Clock),
    .rst_ni     (Reset_n),
    .push_i     (push),
    .wdata_i    (shreg_q),
    .pop_i      (RX_Rd_En),
    .rdata_o    (RX_Bytes),
    .empty_o    (RX_Empty),
    .full_o     (RX_Full),
    .count_o    (RX_Count),
    .push_err_o (push_err)
  );

  assign RX_Frame_Err = frame_err_q;
  assign RX_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frames driven bit by bit on the serial line.
module tb_uart_rx_buffered;

  localparam int unsigned CPB     = 16;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  // Negedges into the stop bit before the cycle whose closing edge samples it.
  localparam int unsigned POP_OFS = 3 + (CPB - 1) / 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx    = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    rx_bytes;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ferr;
  logic          ovr;

  int unsigned n_vec   = 0;
  int unsigned n_err   = 0;
  int unsigned fe_seen = 0;
  int unsigned ov_seen = 0;
  int unsigned fe0;
  int unsigned ov0;

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .Clock        (clk),
    .Reset_n      (rst_n),
    .RX_Serial    (rx),
    .RX_Rd_En     (rd_en),
    .RX_Bytes     (rx_bytes),
    .RX_Empty     (empty),
    .RX_Full      (full),
    .RX_Count     (count),
    .RX_Frame_Err (ferr),
    .RX_Overrun   (ovr)
  );

  // Each cycle a pulse is high adds one, so a stretched pulse shows up as an excess.
  always @(posedge clk) begin
    if (ferr) fe_seen++;
    if (ovr)  ov_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input logic pop_at_push);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == 9 && pop_at_push) begin
        repeat (POP_OFS) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (CPB - POP_OFS - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rx_bytes, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    idle(3);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_bytes", rx_bytes, 8'h00);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    idle(5);

    // Single byte
    fe0 = fe_seen; ov0 = ov_seen;
    send(8'h37, 1'b1, 1'b0);
    idle(4);
    check("t1_empty", empty, 0);
    check("t1_bytes", rx_bytes, 8'h37);
    check("t1_count", count, 1);
    check("t1_ferr", fe_seen - fe0, 0);
    check("t1_ovr", ov_seen - ov0, 0);
    pop_check("t1_pop", 8'h37);
    check("t1_empty_after", empty, 1);

    // Back-to-back frames, ordered drain, pop while empty
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    idle(4);
    check("t2_count", count, 3);
    pop_check("t2_pop0", 8'h00);
    pop_check("t2_pop1", 8'hFF);
    pop_check("t2_pop2", 8'hA5);
    check("t2_empty", empty, 1);
    ov0 = ov_seen;
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    idle(2);
    check("t2_pop_empty_count", count, 0);
    check("t2_pop_empty_ovr", ov_seen - ov0, 0);

    // Framing error, then recovery
    fe0 = fe_seen;
    send(8'h55, 1'b0, 1'b0);
    idle(4);
    check("t3_ferr", fe_seen - fe0, 1);
    check("t3_count", count, 0);
    send(8'h12, 1'b1, 1'b0);
    idle(4);
    check("t3_count2", count, 1);
    check("t3_ferr2", fe_seen - fe0, 1);
    pop_check("t3_pop", 8'h12);

    // Start-bit glitch shorter than half a bit
    fe0 = fe_seen; ov0 = ov_seen;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    check("t4_count", count, 0);
    check("t4_empty", empty, 1);
    check("t4_ferr", fe_seen - fe0, 0);
    check("t4_ovr", ov_seen - ov0, 0);

    // Fill past capacity without pops
    ov0 = ov_seen;
    for (int k = 1; k <= 17; k++) send(8'(k), 1'b1, 1'b0);
    idle(4);
    check("t5_full", full, 1);
    check("t5_count", count, 16);
    check("t5_ovr", ov_seen - ov0, 1);
    for (int k = 1; k <= 16; k++) pop_check("t5_drain", 8'(k));
    check("t5_empty", empty, 1);

    // Same, but with a pop in the 17th push cycle
    ov0 = ov_seen;
    for (int k = 1; k <= 16; k++) send(8'(k), 1'b1, 1'b0);
    send(8'h11, 1'b1, 1'b1);
    idle(4);
    check("t5b_full", full, 1);
    check("t5b_count", count, 16);
    check("t5b_ovr", ov_seen - ov0, 0);
    for (int k = 2; k <= 17; k++) pop_check("t5b_drain", 8'(k));
    check("t5b_empty", empty, 1);

    // Reset in the middle of a frame
    send(8'hA1, 1'b1, 1'b0);
    send(8'hB2, 1'b1, 1'b0);
    send(8'hC4, 1'b1, 1'b0);
    idle(4);
    check("t6_count_pre", count, 3);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1; idle(CPB);
    rx = 1'b1; idle(CPB);
    rx = 1'b0; idle(CPB / 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_empty", empty, 1);
    check("t6_rst_count", count, 0);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2 * CPB);
    check("t6_empty", empty, 1);
    check("t6_count", count, 0);
    send(8'hC3, 1'b1, 1'b0);
    idle(4);
    check("t6_count2", count, 1);
    check("t6_bytes", rx_bytes, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
